onehot_sel_sequencer: RTL and testbench
=======================================

// Module: onehot_sel_sequencer
// PURPOSE
//  Parametrised registered code-to-one-hot select decoder with handshake and timing.
//  Code 0 drives no output; code k (1..N_OUT) drives bit k-1.
//  Adds break-before-make dead time and an optional fixed-length pulse mode.
//  Sits between control logic and mux or enable fan-out that must never see two
//  selects active at once.
// PARAMETERS
//  N_OUT     8   number of one-hot outputs (>=2)
//  CODE_W    $clog2(N_OUT+1)  input code width (derived, not overridden)
//  PULSE_EN  0   0 = level mode (hold selection); 1 = pulse mode
//  PULSE_LEN 4   pulse mode: cycles out_code is asserted (>=1)
//  GAP_LEN   1   cycles of out_code==0 inserted between differing selections (>=0)
// PORTS
//  clk       in   1       single clock, rising edge
//  rst       in   1       synchronous reset, active-high
//  in_valid  in   1       in_code is valid
//  in_ready  out  1       block accepts in_code this cycle
//  in_code   in   CODE_W  requested selection
//  err_clr   in   1       clears err_code
//  out_code  out  N_OUT   registered one-hot select (all-zero = none)
//  active    out  1       registered; equals |out_code
//  err_code  out  1       sticky: an out-of-range code (>N_OUT) was accepted
// BEHAVIOUR
//  Reset values (cycle after rst=1): out_code=0, active=0, err_code=0, state IDLE,
//   in_ready=1. rst overrides every other input, including mid-pulse and mid-gap.
//  Accept = in_valid & in_ready. in_ready is combinational from state only.
//  FSM states IDLE, DRIVE, GAP. Counter width is wide enough for max(PULSE_LEN,GAP_LEN).
//  Level mode (PULSE_EN=0): in_ready=1 in IDLE and DRIVE, 0 in GAP.
//   - Accept code 0 or out-of-range code: out_code<=0 on the next edge; go to IDLE.
//   - Accept k in IDLE, or k equal to the current selection, or GAP_LEN==0:
//     out_code<=onehot(k) on the next edge (1-cycle latency); go to DRIVE.
//   - Accept k != current in DRIVE with GAP_LEN>0: out_code<=0, latch k as
//     pending, go to GAP.
//   - In GAP: out_code stays 0 for exactly GAP_LEN cycles.
//     On the next edge out_code<=onehot(pending); go to DRIVE.
//  Pulse mode (PULSE_EN=1): in_ready=1 only in IDLE.
//   - Accept k valid and nonzero: out_code=onehot(k) for exactly PULSE_LEN cycles.
//   - Then out_code=0 for GAP_LEN cycles (GAP), then return to IDLE.
//   - Accept of 0 or an out-of-range code: no pulse; stay in IDLE.
//  Out-of-range code (>N_OUT) accepted: treated as code 0; err_code<=1.
//   err_code holds until err_clr=1. If set and clear occur in the same cycle, set wins.
//  active is registered alongside out_code and always equals |out_code.
//   out_code is never multi-hot.
//  in_valid with in_ready=0: nothing is consumed. The source holds in_code and
//   in_valid, as in a standard valid/ready handshake.
// STRUCTURE
//  Shared package/header onehot_sel_pkg:
//   - state encodings (IDLE/DRIVE/GAP)
//   - onehot(code) function (code 0 or out-of-range returns 0)
//   - mode constants
//  One sub-module, sel_dwell_counter: loadable down-counter with a done flag.
//   Used for both PULSE_LEN and GAP_LEN timing.
//  FSM, pending register and error flag stay in the top module.
// TESTING  (N_OUT=8 unless noted)
//  1. Reset: hold rst=1 for 2 cycles with in_valid=1, in_code=3 -> out_code=0,
//     err_code=0, in_ready=1 after release.
//  2. Level, GAP_LEN=0: accept 3, then 8, then 0 -> out_code 0x04, 0x80, 0x00 on
//     successive cycles; in_ready stays 1.
//  3. Level, GAP_LEN=2: accept 3, then 5 -> 0x04, 0x00, 0x00 (in_ready=0), 0x10.
//     Then accept 5 again -> stays 0x10 with no gap.
//  4. Pulse, PULSE_LEN=3, GAP_LEN=1: accept 8 -> 0x80 for 3 cycles, 0x00 for 1 cycle.
//     in_ready is low for 4 cycles, then 1. A held in_valid is accepted only after that.
//  5. Accept code 12 (CODE_W=4) -> out_code=0, err_code=1. Next accept 2 -> 0x02 with
//     err_code still 1. err_clr=1 -> err_code=0. err_clr with a simultaneous bad
//     code -> err_code stays 1.
//  6. rst during the 2nd pulse cycle and separately during GAP -> next cycle out_code=0,
//     in_ready=1; a subsequent accept of 1 gives 0x01 with normal timing.

Source files
------------

// File: rtl/onehot_sel_pkg.sv
// Shared definitions for the one-hot select sequencer: FSM states, mode
// constants and the code-to-one-hot decode.
package onehot_sel_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_GAP   = 2'd2
   } sel_state_t;

   localparam bit MODE_LEVEL = 1'b0;
   localparam bit MODE_PULSE = 1'b1;

   // Widest select vector the decode function can produce; callers slice it.
   localparam int SEL_MAX_OUT = 64;
   typedef logic [SEL_MAX_OUT-1:0] sel_vec_t;

   // Code k in 1..n_out maps to bit k-1; code 0 or anything above n_out maps to none.
   function automatic sel_vec_t onehot(input int unsigned code, input int unsigned n_out);
      sel_vec_t v;
      v = '0;
      if (code != 0 && code <= n_out && code <= SEL_MAX_OUT)
         v = sel_vec_t'(1) << (code - 1);
      return v;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/onehot_sel_sequencer_if.sv
// Request/select bundle between control logic (master) and the sequencer (slave).
interface onehot_sel_sequencer_if #(
   parameter int N_OUT = 8
);
   localparam int CODE_W = $clog2(N_OUT + 1);

   logic              in_valid;
   logic              in_ready;
   logic [CODE_W-1:0] in_code;
   logic              err_clr;
   logic [N_OUT-1:0]  out_code;
   logic              active;
   logic              err_code;

   modport master (
      output in_valid, in_code, err_clr,
      input  in_ready, out_code, active, err_code
   );

   modport slave (
      input  in_valid, in_code, err_clr,
      output in_ready, out_code, active, err_code
   );
endinterface

// File: rtl/sel_dwell_counter.sv
// Loadable down-counter; done is high while the count is on its last cycle
// (or idle at zero), so a load of L yields L cycles before done is acted on.
module sel_dwell_counter #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);
   logic [W-1:0] count_reg, count_next;

   always_comb begin
      count_next = count_reg;
      if (load)
         count_next = load_val;
      else if (count_reg != '0)
         count_next = count_reg - W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         count_reg <= '0;
      else
         count_reg <= count_next;
   end

   assign done = (count_reg <= W'(1));
endmodule

// File: rtl/onehot_sel_sequencer.sv
// Registered code-to-one-hot select with break-before-make dead time and an
// optional fixed-length pulse mode; out_code is never multi-hot.
module onehot_sel_sequencer
   import onehot_sel_pkg::*;
#(
   parameter int N_OUT     = 8,
   parameter int PULSE_EN  = 0,
   parameter int PULSE_LEN = 4,
   parameter int GAP_LEN   = 1
) (
   input logic                   clk,
   input logic                   rst,
   onehot_sel_sequencer_if.slave bus
);
   localparam int CODE_W  = $clog2(N_OUT + 1);
   localparam int CNT_MAX = max_int(PULSE_LEN, GAP_LEN);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam bit MODE    = (PULSE_EN != 0) ? MODE_PULSE : MODE_LEVEL;

   sel_state_t       state_reg, state_next;
   logic [N_OUT-1:0] out_reg, out_next;
   logic [N_OUT-1:0] pending_reg, pending_next;
   logic             active_reg;
   logic             err_reg, err_next;

   logic             in_ready_c;
   logic             accept;
   logic             code_ok;
   logic             code_bad;
   sel_vec_t         req_full;
   logic [N_OUT-1:0] req_hot;

   logic             cnt_load;
   logic [CNT_W-1:0] cnt_val;
   logic             cnt_done;

   assign req_full = onehot(32'(bus.in_code), N_OUT);

   genvar gi;
   generate
      for (gi = 0; gi < N_OUT; gi++) begin : g_req
         assign req_hot[gi] = req_full[gi];
      end
      if (N_OUT < SEL_MAX_OUT) begin : g_spare
         logic spare_unused;
         assign spare_unused = |req_full[SEL_MAX_OUT-1:N_OUT];
      end
   endgenerate

   assign code_ok  = |req_hot;
   assign code_bad = (bus.in_code > CODE_W'(N_OUT));

   // Pulse mode blocks new requests for the whole pulse and gap.
   assign in_ready_c = (MODE == MODE_PULSE) ? (state_reg == ST_IDLE)
                                            : (state_reg != ST_GAP);
   assign accept     = bus.in_valid & in_ready_c;

   sel_dwell_counter #(.W(CNT_W)) u_dwell (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .done     (cnt_done)
   );

   always_comb begin
      state_next   = state_reg;
      out_next     = out_reg;
      pending_next = pending_reg;
      err_next     = err_reg;
      cnt_load     = 1'b0;
      cnt_val      = '0;

      // A bad code accepted in the same cycle as a clear keeps the flag set.
      if (accept && code_bad)
         err_next = 1'b1;
      else if (bus.err_clr)
         err_next = 1'b0;

      if (MODE == MODE_LEVEL) begin
         case (state_reg)
            ST_IDLE, ST_DRIVE: begin
               if (accept) begin
                  if (!code_ok) begin
                     out_next   = '0;
                     state_next = ST_IDLE;
                  end else if (state_reg == ST_IDLE || req_hot == out_reg || GAP_LEN == 0) begin
                     out_next   = req_hot;
                     state_next = ST_DRIVE;
                  end else begin
                     out_next     = '0;
                     pending_next = req_hot;
                     state_next   = ST_GAP;
                     cnt_load     = 1'b1;
                     cnt_val      = CNT_W'(GAP_LEN);
                  end
               end
            end
            ST_GAP: begin
               if (cnt_done) begin
                  out_next   = pending_reg;
                  state_next = ST_DRIVE;
               end
            end
            default: begin
               out_next   = '0;
               state_next = ST_IDLE;
            end
         endcase
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (accept && code_ok) begin
                  out_next   = req_hot;
                  state_next = ST_DRIVE;
                  cnt_load   = 1'b1;
                  cnt_val    = CNT_W'(PULSE_LEN);
               end
            end
            ST_DRIVE: begin
               if (cnt_done) begin
                  out_next = '0;
                  if (GAP_LEN > 0) begin
                     state_next = ST_GAP;
                     cnt_load   = 1'b1;
                     cnt_val    = CNT_W'(GAP_LEN);
                  end else begin
                     state_next = ST_IDLE;
                  end
               end
            end
            ST_GAP: begin
               if (cnt_done)
                  state_next = ST_IDLE;
            end
            default: begin
               out_next   = '0;
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         out_reg     <= '0;
         pending_reg <= '0;
         active_reg  <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         out_reg     <= out_next;
         pending_reg <= pending_next;
         active_reg  <= |out_next;
         err_reg     <= err_next;
      end
   end

   assign bus.in_ready = in_ready_c;
   assign bus.out_code = out_reg;
   assign bus.active   = active_reg;
   assign bus.err_code = err_reg;
endmodule

// File: tb/tb_onehot_sel_sequencer.sv
// Self-checking bench: three sequencer configurations driven from step tables,
// expected observations queued at drive time and compared after the edge.
module tb_onehot_sel_sequencer;

   typedef struct packed {
      logic       rst;
      logic       vld;
      logic [3:0] code;
      logic       clr;
      logic [7:0] eout;
      logic       erdy;
      logic       eerr;
   } step_t;

   typedef struct packed {
      logic [7:0] out;
      logic       act;
      logic       rdy;
      logic       err;
   } obs_t;

   localparam int ID_G0 = 0;
   localparam int ID_G2 = 1;
   localparam int ID_P  = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;
   obs_t sb[$];

   always #5 clk = ~clk;

   onehot_sel_sequencer_if #(.N_OUT(8)) bus_g0 ();
   onehot_sel_sequencer_if #(.N_OUT(8)) bus_g2 ();
   onehot_sel_sequencer_if #(.N_OUT(8)) bus_p  ();

   onehot_sel_sequencer #(.N_OUT(8), .PULSE_EN(0), .PULSE_LEN(4), .GAP_LEN(0)) u_g0 (
      .clk (clk), .rst (rst), .bus (bus_g0));
   onehot_sel_sequencer #(.N_OUT(8), .PULSE_EN(0), .PULSE_LEN(4), .GAP_LEN(2)) u_g2 (
      .clk (clk), .rst (rst), .bus (bus_g2));
   onehot_sel_sequencer #(.N_OUT(8), .PULSE_EN(1), .PULSE_LEN(3), .GAP_LEN(1)) u_p (
      .clk (clk), .rst (rst), .bus (bus_p));

   function automatic step_t mk(input bit r, input bit v, input int c, input bit e,
                                input int o, input bit rdy, input bit er);
      step_t s;
      s.rst  = r;
      s.vld  = v;
      s.code = 4'(c);
      s.clr  = e;
      s.eout = 8'(o);
      s.erdy = rdy;
      s.eerr = er;
      return s;
   endfunction

   function automatic obs_t expect_of(input step_t s);
      obs_t o;
      o.out = s.eout;
      o.act = |s.eout;
      o.rdy = s.erdy;
      o.err = s.eerr;
      return o;
   endfunction

   task automatic drive(input int id, input step_t s);
      rst             = s.rst;
      bus_g0.in_valid = (id == ID_G0) && s.vld;
      bus_g0.in_code  = s.code;
      bus_g0.err_clr  = (id == ID_G0) && s.clr;
      bus_g2.in_valid = (id == ID_G2) && s.vld;
      bus_g2.in_code  = s.code;
      bus_g2.err_clr  = (id == ID_G2) && s.clr;
      bus_p.in_valid  = (id == ID_P) && s.vld;
      bus_p.in_code   = s.code;
      bus_p.err_clr   = (id == ID_P) && s.clr;
   endtask

   function automatic obs_t sample(input int id);
      obs_t o;
      case (id)
         ID_G0:   begin o.out = bus_g0.out_code; o.act = bus_g0.active; o.rdy = bus_g0.in_ready; o.err = bus_g0.err_code; end
         ID_G2:   begin o.out = bus_g2.out_code; o.act = bus_g2.active; o.rdy = bus_g2.in_ready; o.err = bus_g2.err_code; end
         default: begin o.out = bus_p.out_code;  o.act = bus_p.active;  o.rdy = bus_p.in_ready;  o.err = bus_p.err_code;  end
      endcase
      return o;
   endfunction

   task automatic test_reset();
      step_t steps [2];
      obs_t  got, want;
      steps = '{mk(1,1,3,0,'h00,1,0), mk(1,1,3,0,'h00,1,0)};
      foreach (steps[i]) begin
         drive(ID_G0, steps[i]);
         sb.push_back(expect_of(steps[i]));
         @(posedge clk); #1;
         got = sample(ID_G0); want = sb.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL reset step %0d: got out=%h act=%b rdy=%b err=%b, expected out=%h act=%b rdy=%b err=%b",
                     i, got.out, got.act, got.rdy, got.err, want.out, want.act, want.rdy, want.err);
         end else
            $display("ok   reset step %0d: out=%h rdy=%b err=%b", i, got.out, got.rdy, got.err);
      end
   endtask

   task automatic test_level_nogap();
      step_t steps [4];
      obs_t  got, want;
      steps = '{mk(0,1,3,0,'h04,1,0), mk(0,1,8,0,'h80,1,0), mk(0,1,0,0,'h00,1,0),
                mk(0,0,0,0,'h00,1,0)};
      foreach (steps[i]) begin
         drive(ID_G0, steps[i]);
         sb.push_back(expect_of(steps[i]));
         @(posedge clk); #1;
         got = sample(ID_G0); want = sb.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL level_nogap step %0d: got out=%h act=%b rdy=%b err=%b, expected out=%h act=%b rdy=%b err=%b",
                     i, got.out, got.act, got.rdy, got.err, want.out, want.act, want.rdy, want.err);
         end else
            $display("ok   level_nogap step %0d: out=%h rdy=%b err=%b", i, got.out, got.rdy, got.err);
      end
   endtask

   task automatic test_level_gap();
      step_t steps [7];
      obs_t  got, want;
      steps = '{mk(0,1,3,0,'h04,1,0), mk(0,1,5,0,'h00,0,0), mk(0,0,0,0,'h00,0,0),
                mk(0,0,0,0,'h10,1,0), mk(0,1,5,0,'h10,1,0), mk(0,0,0,0,'h10,1,0),
                mk(0,1,0,0,'h00,1,0)};
      foreach (steps[i]) begin
         drive(ID_G2, steps[i]);
         sb.push_back(expect_of(steps[i]));
         @(posedge clk); #1;
         got = sample(ID_G2); want = sb.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL level_gap step %0d: got out=%h act=%b rdy=%b err=%b, expected out=%h act=%b rdy=%b err=%b",
                     i, got.out, got.act, got.rdy, got.err, want.out, want.act, want.rdy, want.err);
         end else
            $display("ok   level_gap step %0d: out=%h rdy=%b err=%b", i, got.out, got.rdy, got.err);
      end
   endtask

   task automatic test_pulse();
      step_t steps [11];
      obs_t  got, want;
      // Code 0 gives no pulse; then code 8 held until accepted twice over.
      steps = '{mk(0,1,0,0,'h00,1,0),
                mk(0,1,8,0,'h80,0,0), mk(0,1,8,0,'h80,0,0), mk(0,1,8,0,'h80,0,0),
                mk(0,1,8,0,'h00,0,0), mk(0,1,8,0,'h00,1,0),
                mk(0,1,8,0,'h80,0,0), mk(0,0,0,0,'h80,0,0), mk(0,0,0,0,'h80,0,0),
                mk(0,0,0,0,'h00,0,0), mk(0,0,0,0,'h00,1,0)};
      foreach (steps[i]) begin
         drive(ID_P, steps[i]);
         sb.push_back(expect_of(steps[i]));
         @(posedge clk); #1;
         got = sample(ID_P); want = sb.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL pulse step %0d: got out=%h act=%b rdy=%b err=%b, expected out=%h act=%b rdy=%b err=%b",
                     i, got.out, got.act, got.rdy, got.err, want.out, want.act, want.rdy, want.err);
         end else
            $display("ok   pulse step %0d: out=%h rdy=%b err=%b", i, got.out, got.rdy, got.err);
      end
   endtask

   task automatic test_err_flag();
      step_t steps [6];
      obs_t  got, want;
      steps = '{mk(0,1,12,0,'h00,1,1), mk(0,1,2,0,'h02,1,1), mk(0,0,0,1,'h02,1,0),
                mk(0,1,12,1,'h00,1,1), mk(0,0,0,0,'h00,1,1), mk(0,0,0,1,'h00,1,0)};
      foreach (steps[i]) begin
         drive(ID_G0, steps[i]);
         sb.push_back(expect_of(steps[i]));
         @(posedge clk); #1;
         got = sample(ID_G0); want = sb.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL err_flag step %0d: got out=%h act=%b rdy=%b err=%b, expected out=%h act=%b rdy=%b err=%b",
                     i, got.out, got.act, got.rdy, got.err, want.out, want.act, want.rdy, want.err);
         end else
            $display("ok   err_flag step %0d: out=%h rdy=%b err=%b", i, got.out, got.rdy, got.err);
      end
   endtask

   task automatic test_reset_mid_pulse();
      step_t steps [8];
      obs_t  got, want;
      steps = '{mk(0,1,1,0,'h01,0,0), mk(0,0,0,0,'h01,0,0), mk(1,0,0,0,'h00,1,0),
                mk(0,1,1,0,'h01,0,0), mk(0,0,0,0,'h01,0,0), mk(0,0,0,0,'h01,0,0),
                mk(0,0,0,0,'h00,0,0), mk(0,0,0,0,'h00,1,0)};
      foreach (steps[i]) begin
         drive(ID_P, steps[i]);
         sb.push_back(expect_of(steps[i]));
         @(posedge clk); #1;
         got = sample(ID_P); want = sb.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL rst_mid_pulse step %0d: got out=%h act=%b rdy=%b err=%b, expected out=%h act=%b rdy=%b err=%b",
                     i, got.out, got.act, got.rdy, got.err, want.out, want.act, want.rdy, want.err);
         end else
            $display("ok   rst_mid_pulse step %0d: out=%h rdy=%b err=%b", i, got.out, got.rdy, got.err);
      end
   endtask

   task automatic test_reset_mid_gap();
      step_t steps [5];
      obs_t  got, want;
      steps = '{mk(0,1,2,0,'h02,1,0), mk(0,1,4,0,'h00,0,0), mk(1,0,0,0,'h00,1,0),
                mk(0,1,1,0,'h01,1,0), mk(0,0,0,0,'h01,1,0)};
      foreach (steps[i]) begin
         drive(ID_G2, steps[i]);
         sb.push_back(expect_of(steps[i]));
         @(posedge clk); #1;
         got = sample(ID_G2); want = sb.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL rst_mid_gap step %0d: got out=%h act=%b rdy=%b err=%b, expected out=%h act=%b rdy=%b err=%b",
                     i, got.out, got.act, got.rdy, got.err, want.out, want.act, want.rdy, want.err);
         end else
            $display("ok   rst_mid_gap step %0d: out=%h rdy=%b err=%b", i, got.out, got.rdy, got.err);
      end
   endtask

   initial begin
      drive(ID_G0, mk(0,0,0,0,0,1,0));
      test_reset();
      test_level_nogap();
      test_level_gap();
      test_pulse();
      test_err_flag();
      test_reset_mid_pulse();
      test_reset_mid_gap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
